snap_phase_capture_ctrl: RTL and testbench
==========================================

Name: snap_phase_capture_ctrl

Overview:
Sequences a snapshot capture of the channelizer phase stream into a snap BRAM, under control of the software-written 32-bit snapPhase control word. It arms on a rising edge of the control word's arm bit. It then optionally waits for a trigger and writes a programmable number of samples. It reports busy/done/count in a status word read back by the PPC. It sits between the OPB control register's user_data_out, the phase datapath and the snap BRAM port.

Parameters:
DATA_W, 32, width of phase sample and BRAM data
ADDR_W, 11, BRAM address width; max capture DEPTH = 2**ADDR_W

Ports:
user_clk  in  1  single clock for all logic
user_rst  in  1  asynchronous, active-high reset
ctrl_word  in  32  software control word: [0] arm, [1] use_trig, [2] abort, [16+ADDR_W-1:16] last_addr (number of samples minus 1)
data_in  in  DATA_W  phase sample
data_valid  in  1  data_in qualifier
trig_in  in  1  external trigger, sampled only with data_valid
bram_addr  out  ADDR_W  snap BRAM write address
bram_din  out  DATA_W  snap BRAM write data
bram_we  out  1  snap BRAM write enable
status_out  out  32  [ADDR_W-1:0] samples written, [29] waiting_trig, [30] busy, [31] done; other bits 0

Behaviour:
- Reset (async, active-high): state IDLE; bram_addr=0, bram_din=0, bram_we=0, status_out=0; count=0; arm_q=1, so an arm bit held high through reset does not start a capture.
- arm_edge = ctrl_word[0] & ~arm_q; arm_q <= ctrl_word[0] every cycle.
- ctrl_word is quasi-static, written from another domain through the register block. It is used directly without a synchronizer.
- last_addr is latched into an internal register on arm_edge. Later changes do not affect the capture in progress.
- States: IDLE, WAIT_TRIG, CAPTURE, DONE.
  - IDLE/DONE + arm_edge: clear count and done. Go to WAIT_TRIG if use_trig=1, otherwise CAPTURE. The transition takes effect next cycle.
  - WAIT_TRIG + data_valid & trig_in: that same sample is the first captured sample (addr 0). Go to CAPTURE.
  - CAPTURE + data_valid: capture the sample.
  - Capturing the sample with count==last_addr_latched: go to DONE.
  - DONE holds until arm_edge or abort.
- Write pipeline: a sample captured at cycle c drives bram_we=1, bram_addr=count, bram_din=data_in at c+1, so latency is 1 cycle. count increments by 1 per captured sample. bram_we is 0 on all other cycles. Writes are never back-pressured.
- Status: busy=1 in WAIT_TRIG or CAPTURE. waiting_trig=1 in WAIT_TRIG. done=1 in DONE. The count field holds samples written so far, read-only. All status bits are registered and updated in the same cycle as the corresponding bram_we.
- Boundaries:
  - last_addr=0 captures exactly 1 sample.
  - last_addr=DEPTH-1 fills the BRAM.
  - The count field wraps with no extra write; it cannot exceed last_addr+1 because capture stops.
  - arm_edge while busy is ignored, but arm_q still updates.
  - abort=1 (level) forces IDLE from any state and clears done and busy. The sample at that cycle is not captured and bram_we is 0 the next cycle. The count field keeps its value until the next arm.
  - abort and arm_edge in the same cycle: abort wins. The edge is consumed, so software must re-toggle arm.
  - trig_in without data_valid is ignored.

Optional Feature:
SNAP_PHASE_TIMESTAMP_EN
- Defined: adds a free-running 32-bit cycle counter, reset to 0 and wrapping modulo 2**32. Adds output port trig_time [31:0], reset 0. trig_time latches the counter value on the cycle the first sample (addr 0) is captured, and holds until the next first-sample capture.
- Undefined: no counter and no trig_time port; all other behaviour is identical.

Test Plan:
- Reset, then ctrl_word=0x0007_0001 (last_addr=7, no trig), data_valid=1 every cycle with data = 0x100+n -> 8 writes at addr 0..7 on consecutive cycles, first write 2 cycles after the arm write. Then status_out=0x8000_0008 and bram_we stays 0.
- ctrl_word=0x0003_0003 (use_trig, last_addr=3); trig_in pulsed with valid sample 0xAB -> status bit29 high before the trigger. Writes 0xAB,... to addr 0..3. trig_in pulses without data_valid produce no capture.
- Capture in progress (last_addr=15), data_valid toggling 1/0 -> exactly 16 writes with contiguous addresses and no gaps in address despite gaps in valid.
- Mid-capture, after 5 writes, ctrl_word[2]=1 -> next cycle bram_we=0 and status_out=0x0000_0005. Then abort=0 and an arm re-edge restarts the capture from addr 0.
- Arm re-toggled while busy, and arm+abort in the same cycle -> no restart and no extra writes. ctrl bit0 held 1 through reset release -> no capture.
- With SNAP_PHASE_TIMESTAMP_EN: trigger at counter value 0x0000_0123 -> trig_time=0x0000_0123 from the first write onward, unchanged through DONE.

Source files
------------

// File: rtl/snap_phase_capture_ctrl.sv
// Snapshot capture sequencer: arms on a rising edge of ctrl_word[0], optionally waits for a trigger,
// then writes last_addr+1 phase samples to the snap BRAM. Optional trig_time port: SNAP_PHASE_TIMESTAMP_EN.
module snap_phase_capture_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_word,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              trig_in,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic [31:0]       status_out
`ifdef SNAP_PHASE_TIMESTAMP_EN
  ,
  output logic [31:0]       trig_time
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                arm_q;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                wait_q, wait_d;

  logic                arm_edge;
  logic                abort;
  logic                use_trig;
  logic [ADDR_W-1:0]   last_in;
  logic                capture;

  // ctrl_word is quasi-static software state, so it is consumed without a synchronizer.
  assign arm_edge = ctrl_word[0] & ~arm_q;
  assign use_trig = ctrl_word[1];
  assign abort    = ctrl_word[2];
  assign last_in  = ctrl_word[16 +: ADDR_W];

  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_word[31:16+ADDR_W], ctrl_word[15:3]};

  assign capture = ~abort & data_valid &
                   ((state_q == CAPTURE) | ((state_q == WAIT_TRIG) & trig_in));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    count_d = count_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm_edge) begin
            state_d = use_trig ? WAIT_TRIG : CAPTURE;
            count_d = '0;
            last_d  = last_in;
          end
        end
        WAIT_TRIG, CAPTURE: begin
          if (capture) begin
            we_d    = 1'b1;
            addr_d  = count_q;
            din_d   = data_in;
            count_d = count_q + 1'b1;
            state_d = (count_q == last_q) ? DONE : CAPTURE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Status flags are registered alongside the write so software sees them move with bram_we.
    done_d = (state_d == DONE);
    busy_d = (state_d == WAIT_TRIG) | (state_d == CAPTURE);
    wait_d = (state_d == WAIT_TRIG);
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q <= IDLE;
      arm_q   <= 1'b1;
      last_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= ctrl_word[0];
      last_q  <= last_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      wait_q  <= wait_d;
    end
  end

  assign bram_addr  = addr_q;
  assign bram_din   = din_q;
  assign bram_we    = we_q;
  assign status_out = {done_q, busy_q, wait_q, {(29-ADDR_W){1'b0}}, count_q};

`ifdef SNAP_PHASE_TIMESTAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] trig_time_q;

  // The first captured sample always sees count_q==0; the wrap at full depth ends the capture.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      cyc_q       <= '0;
      trig_time_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (capture && (count_q == '0)) begin
        trig_time_q <= cyc_q;
      end
    end
  end

  assign trig_time = trig_time_q;
`endif

endmodule

// File: tb/tb_snap_phase_capture_ctrl.sv
// Randomized and directed bench for snap_phase_capture_ctrl against a transaction-level model.
module tb_snap_phase_capture_ctrl;

  logic        user_clk;
  logic        user_rst;
  logic [31:0] ctrl_word;
  logic [31:0] data_in;
  logic        data_valid;
  logic        trig_in;
  logic [10:0] bram_addr;
  logic [31:0] bram_din;
  logic        bram_we;
  logic [31:0] status_out;

  int checks;
  int failures;
  int cyc_n;
  int wr;

  // Model: a capture is "active" while samples are still owed; target is the sample count.
  logic        m_prev_arm;
  logic        m_active;
  logic        m_wait;
  logic        m_done;
  int          m_cnt;
  int          m_target;
  logic        exp_we;
  logic [10:0] exp_addr;
  logic [31:0] exp_din;
  logic [31:0] exp_status;

  logic [31:0]  tt_obs;
  logic [31:0]  tt_exp;
  logic [107:0] obs_v;
  logic [107:0] exp_v;

`ifdef SNAP_PHASE_TIMESTAMP_EN
  logic [31:0] trig_time;
  logic [31:0] m_cyc;
  logic [31:0] exp_tt;
  assign tt_obs = trig_time;
  assign tt_exp = exp_tt;
`else
  assign tt_obs = '0;
  assign tt_exp = '0;
`endif

  snap_phase_capture_ctrl dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .ctrl_word  (ctrl_word),
    .data_in    (data_in),
    .data_valid (data_valid),
    .trig_in    (trig_in),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_we    (bram_we),
`ifdef SNAP_PHASE_TIMESTAMP_EN
    .trig_time  (trig_time),
`endif
    .status_out (status_out)
  );

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  assign obs_v = {bram_we, status_out, bram_we ? bram_addr : 11'd0, bram_we ? bram_din : 32'd0, tt_obs};
  assign exp_v = {exp_we, exp_status, exp_we ? exp_addr : 11'd0, exp_we ? exp_din : 32'd0, tt_exp};

  // One clock: model consumes the inputs sampled at this edge, outputs are then settled.
  task automatic tick();
    logic arm;
    @(posedge user_clk);
    arm        = ctrl_word[0] && !m_prev_arm;
    m_prev_arm = ctrl_word[0];
    exp_we     = 1'b0;
    if (ctrl_word[2]) begin
      m_active = 1'b0;
      m_wait   = 1'b0;
      m_done   = 1'b0;
    end else if (!m_active && arm) begin
      m_active = 1'b1;
      m_wait   = ctrl_word[1];
      m_done   = 1'b0;
      m_cnt    = 0;
      m_target = int'(ctrl_word[26:16]) + 1;
    end else if (m_active && data_valid && (!m_wait || trig_in)) begin
      exp_we   = 1'b1;
      exp_addr = 11'(m_cnt);
      exp_din  = data_in;
`ifdef SNAP_PHASE_TIMESTAMP_EN
      if (m_cnt == 0) exp_tt = m_cyc;
`endif
      m_cnt  = m_cnt + 1;
      m_wait = 1'b0;
      if (m_cnt == m_target) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
`ifdef SNAP_PHASE_TIMESTAMP_EN
    m_cyc = m_cyc + 32'd1;
`endif
    exp_status = {m_done, m_active, m_active && m_wait, 18'd0, 11'(m_cnt)};
    #1;
    cyc_n = cyc_n + 1;
  endtask

  task automatic test_reset();
    user_rst   = 1'b1;
    ctrl_word  = 32'h0000_0001;
    data_valid = 1'b1;
    data_in    = 32'h5555_5555;
    trig_in    = 1'b0;
    m_prev_arm = 1'b1;
    m_active   = 1'b0;
    m_wait     = 1'b0;
    m_done     = 1'b0;
    m_cnt      = 0;
    m_target   = 1;
    exp_we     = 1'b0;
    exp_addr   = '0;
    exp_din    = '0;
    exp_status = '0;
`ifdef SNAP_PHASE_TIMESTAMP_EN
    m_cyc  = '0;
    exp_tt = '0;
`endif
    repeat (3) @(posedge user_clk);
    #1;
    if ({bram_we, bram_addr, bram_din, status_out} !== 76'd0) begin
      failures++;
      $display("FAIL reset_values got we=%b addr=%h din=%h status=%h want all zero",
               bram_we, bram_addr, bram_din, status_out);
    end
    checks++;
    @(negedge user_clk);
    user_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_in = $urandom;
      tick();
      if (bram_we !== 1'b0 || status_out !== 32'd0 || obs_v !== exp_v) begin
        failures++;
        $display("FAIL reset_arm_held cyc=%0d got we=%b status=%h want we=0 status=0", cyc_n, bram_we, status_out);
      end
      checks++;
    end
  endtask

  task automatic test_basic();
    int k;
    ctrl_word  = 32'h0;
    data_valid = 1'b1;
    tick();
    k         = cyc_n + 1;
    ctrl_word = 32'h0007_0001;
    wr        = 0;
    for (int i = 0; i < 14; i++) begin
      data_in = 32'(32'h100 + i - 1);
      tick();
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL basic_model cyc=%0d got=%h want=%h", cyc_n, obs_v, exp_v);
      end
      checks++;
      if (bram_we) begin
        if (cyc_n != k + 1 + wr || bram_addr !== 11'(wr) || bram_din !== 32'(32'h100 + wr)) begin
          failures++;
          $display("FAIL basic_write n=%0d got cyc=%0d addr=%h din=%h want cyc=%0d addr=%h din=%h",
                   wr, cyc_n, bram_addr, bram_din, k + 1 + wr, wr, 32'h100 + wr);
        end
        checks++;
        wr++;
      end
    end
    if (wr != 8 || status_out !== 32'h8000_0008) begin
      failures++;
      $display("FAIL basic_done got writes=%0d status=%h want writes=8 status=80000008", wr, status_out);
    end
    checks++;
  endtask

  task automatic test_trigger();
    ctrl_word  = 32'h0;
    data_valid = 1'b0;
    trig_in    = 1'b0;
    tick();
    ctrl_word = 32'h0003_0003;
    tick();
    for (int i = 0; i < 3; i++) begin
      trig_in = 1'b1;
      tick();
      if (status_out[29] !== 1'b1 || bram_we !== 1'b0 || obs_v !== exp_v) begin
        failures++;
        $display("FAIL trig_wait cyc=%0d got status=%h we=%b want bit29=1 we=0", cyc_n, status_out, bram_we);
      end
      checks++;
    end
    wr = 0;
    for (int i = 0; i < 7; i++) begin
      data_valid = 1'b1;
      trig_in    = (i == 0);
      data_in    = 32'(32'hAB + i);
      tick();
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL trig_model cyc=%0d got=%h want=%h", cyc_n, obs_v, exp_v);
      end
      checks++;
      if (bram_we) begin
        if (bram_addr !== 11'(wr) || bram_din !== 32'(32'hAB + wr)) begin
          failures++;
          $display("FAIL trig_write n=%0d got addr=%h din=%h want addr=%h din=%h",
                   wr, bram_addr, bram_din, wr, 32'hAB + wr);
        end
        checks++;
        wr++;
      end
    end
    if (wr != 4 || status_out !== 32'h8000_0004) begin
      failures++;
      $display("FAIL trig_done got writes=%0d status=%h want writes=4 status=80000004", wr, status_out);
    end
    checks++;
    trig_in = 1'b0;
  endtask

  task automatic test_gappy_valid();
    ctrl_word  = 32'h0;
    data_valid = 1'b0;
    tick();
    ctrl_word = 32'h000F_0001;
    tick();
    wr = 0;
    for (int i = 0; i < 40; i++) begin
      data_valid = i[0];
      data_in    = $urandom;
      tick();
      if (obs_v !== exp_v || (bram_we && bram_addr !== 11'(wr))) begin
        failures++;
        $display("FAIL gappy cyc=%0d got=%h want=%h next_addr=%0d", cyc_n, obs_v, exp_v, wr);
      end
      checks++;
      if (bram_we) wr++;
    end
    if (wr != 16 || status_out !== 32'h8000_0010) begin
      failures++;
      $display("FAIL gappy_done got writes=%0d status=%h want writes=16 status=80000010", wr, status_out);
    end
    checks++;
  endtask

  task automatic test_abort();
    int n;
    ctrl_word  = 32'h0;
    data_valid = 1'b1;
    tick();
    ctrl_word = 32'h000F_0001;
    tick();
    wr = 0;
    n  = 0;
    while (wr < 5 && n < 20) begin
      data_in = $urandom;
      tick();
      if (bram_we) wr++;
      n++;
    end
    if (wr != 5) begin
      failures++;
      $display("FAIL abort_setup got writes=%0d want 5 within 20 cycles", wr);
    end
    checks++;
    ctrl_word = 32'h000F_0005;
    tick();
    if (bram_we !== 1'b0 || status_out !== 32'h0000_0005 || obs_v !== exp_v) begin
      failures++;
      $display("FAIL abort_stop got we=%b status=%h want we=0 status=00000005", bram_we, status_out);
    end
    checks++;
    ctrl_word = 32'h000F_0000;
    tick();
    ctrl_word = 32'h000F_0001;
    tick();
    tick();
    if (bram_we !== 1'b1 || bram_addr !== 11'd0 || obs_v !== exp_v) begin
      failures++;
      $display("FAIL abort_restart got we=%b addr=%h want we=1 addr=0", bram_we, bram_addr);
    end
    checks++;
    for (int i = 0; i < 24; i++) begin
      data_in = $urandom;
      tick();
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL abort_drain cyc=%0d got=%h want=%h", cyc_n, obs_v, exp_v);
      end
      checks++;
    end
  endtask

  task automatic test_busy_rearm();
    ctrl_word  = 32'h0;
    data_valid = 1'b0;
    tick();
    ctrl_word = 32'h000F_0001;
    tick();
    tick();
    ctrl_word = 32'h0003_0000;
    tick();
    ctrl_word = 32'h0003_0001;
    tick();
    if (status_out !== 32'h4000_0000 || bram_we !== 1'b0 || obs_v !== exp_v) begin
      failures++;
      $display("FAIL rearm_busy got status=%h we=%b want status=40000000 we=0", status_out, bram_we);
    end
    checks++;
    wr = 0;
    for (int i = 0; i < 24; i++) begin
      data_valid = 1'b1;
      data_in    = $urandom;
      tick();
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL rearm_capture cyc=%0d got=%h want=%h", cyc_n, obs_v, exp_v);
      end
      checks++;
      if (bram_we) wr++;
    end
    if (wr != 16 || status_out !== 32'h8000_0010) begin
      failures++;
      $display("FAIL rearm_length got writes=%0d status=%h want writes=16 status=80000010", wr, status_out);
    end
    checks++;
    ctrl_word = 32'h0003_0000;
    tick();
    ctrl_word = 32'h0003_0005;
    tick();
    ctrl_word = 32'h0003_0001;
    wr = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bram_we) wr++;
    end
    if (wr != 0 || status_out !== 32'h0000_0010 || obs_v !== exp_v) begin
      failures++;
      $display("FAIL arm_abort_same got writes=%0d status=%h want writes=0 status=00000010", wr, status_out);
    end
    checks++;
  endtask

  task automatic test_full_depth();
    logic [10:0] last_a;
    ctrl_word  = 32'h0;
    data_valid = 1'b1;
    tick();
    ctrl_word = 32'h07FF_0001;
    wr     = 0;
    last_a = '0;
    for (int i = 0; i < 2060; i++) begin
      data_in = $urandom;
      tick();
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL full_model cyc=%0d got=%h want=%h", cyc_n, obs_v, exp_v);
      end
      checks++;
      if (bram_we) begin
        wr++;
        last_a = bram_addr;
      end
    end
    if (wr != 2048 || last_a !== 11'h7FF || status_out !== 32'h8000_0000) begin
      failures++;
      $display("FAIL full_depth got writes=%0d last=%h status=%h want writes=2048 last=7ff status=80000000",
               wr, last_a, status_out);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) begin
        ctrl_word        = $urandom;
        ctrl_word[2]     = ($urandom_range(7) == 0);
        ctrl_word[26:16] = 11'($urandom_range(12));
      end
      data_valid = ($urandom_range(3) != 0);
      trig_in    = ($urandom_range(5) == 0);
      data_in    = $urandom;
      tick();
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL random cyc=%0d ctrl=%h got=%h want=%h", cyc_n, ctrl_word, obs_v, exp_v);
      end
      checks++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc_n    = 0;
    wr       = 0;
    test_reset();
    test_basic();
    test_trigger();
    test_gappy_valid();
    test_abort();
    test_busy_rearm();
    test_full_depth();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
